core_unloader: RTL

- Hardware reader for the sat_engine load/readback interface. It drains a finished core back to bin memory.
- After the controller sees done_core_o, it pulses start_i. The block then does three things in order:
  - snapshots vars_states_o and lvl_states_o;
  - walks the clause array one row at a time using one-hot rd_carray;
  - streams every clause, var-state and lvl-state word out on a valid/ready write port tagged with bin id, kind and index.
- It sits between sat_engine and the bin-memory arbiter. It is the mirror of the bin loading sequence.

---
 rtl/sat_pkg.sv | 29 ++
 rtl/core_unloader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sat_pkg.sv
// Shared types for the sat_engine readback path.
package sat_pkg;

    localparam int WIDTH_UNLOAD_KIND = 2;

    typedef enum logic [WIDTH_UNLOAD_KIND-1:0] {
        KIND_CLAUSE = 2'd0,
        KIND_VAR    = 2'd1,
        KIND_LVL    = 2'd2
    } unload_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_RD_C,
        ST_CAP_C,
        ST_EMIT_C,
        ST_EMIT_V,
        ST_EMIT_L,
        ST_DONE
    } unload_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/core_unloader.sv
// Drains a finished sat_engine core back to bin memory: snapshot the
// var/lvl state, fetch clause rows one at a time, stream everything out.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start_i, bin id latched on accept
// ST_SNAP   | register vars/lvl state vectors, reset index
// ST_RD_C   | one-hot row select to the engine for clause idx
// ST_CAP_C  | engine output valid, capture clause into holding register
// ST_EMIT_C | offer clause word, advance on ready
// ST_EMIT_V | offer var-state word idx from snapshot
// ST_EMIT_L | offer lvl-state word idx from snapshot
// ST_DONE   | one-cycle done pulse, back to idle
module core_unloader
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_DATA       = 19
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    input  logic [2*NUM_VARS-1:0]                clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 wr_valid_o,
    input  logic                                 wr_ready_i,
    output logic [WIDTH_UNLOAD_KIND-1:0]         wr_kind_o,
    output logic [7:0]                           wr_idx_o,
    output logic [WIDTH_BIN_ID-1:0]              wr_bin_o,
    output logic [WIDTH_DATA-1:0]                wr_data_o
);

    localparam int MAX_CNT   = max3(NUM_CLAUSES, NUM_VARS, NUM_LVLS);
    localparam int WIDTH_IDX = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    unload_state_e                                r_state;
    unload_kind_e                                 r_kind;
    logic [WIDTH_IDX-1:0]                         r_idx;
    logic [WIDTH_BIN_ID-1:0]                      r_bin;
    logic [NUM_VARS-1:0][WIDTH_VAR_STATES-1:0]    r_vars;
    logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0]    r_lvls;
    logic [2*NUM_VARS-1:0]                        r_hold;
    logic                                         r_busy;
    logic                                         r_done;
    logic                                         r_valid;
    logic [NUM_CLAUSES-1:0]                       r_rd;
    logic [WIDTH_DATA-1:0]                        w_data;

    // Sequencer: state, index, snapshots and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_kind  <= KIND_CLAUSE;
            r_idx   <= '0;
            r_bin   <= '0;
            r_vars  <= '0;
            r_lvls  <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_done <= 1'b0;
            r_rd   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_bin   <= bin_id_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    r_vars  <= vars_states_i;
                    r_lvls  <= lvl_states_i;
                    r_idx   <= '0;
                    r_rd    <= NUM_CLAUSES'(1);
                    r_state <= ST_RD_C;
                end
                ST_RD_C: begin
                    r_state <= ST_CAP_C;
                end
                ST_CAP_C: begin
                    r_hold  <= clause_i;
                    r_kind  <= KIND_CLAUSE;
                    r_valid <= 1'b1;
                    r_state <= ST_EMIT_C;
                end
                ST_EMIT_C: begin
                    if (wr_ready_i) begin
                        if (r_idx == WIDTH_IDX'(NUM_CLAUSES - 1)) begin
                            r_idx   <= '0;
                            r_kind  <= KIND_VAR;
                            r_state <= ST_EMIT_V;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_valid <= 1'b0;
                            r_rd    <= NUM_CLAUSES'(1) << (r_idx + 1'b1);
                            r_state <= ST_RD_C;
                        end
                    end
                end
                ST_EMIT_V: begin
                    if (wr_ready_i) begin
                        if (r_idx == WIDTH_IDX'(NUM_VARS - 1)) begin
                            r_idx   <= '0;
                            r_kind  <= KIND_LVL;
                            r_state <= ST_EMIT_L;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_EMIT_L: begin
                    if (wr_ready_i) begin
                        if (r_idx == WIDTH_IDX'(NUM_LVLS - 1)) begin
                            r_idx   <= '0;
                            r_kind  <= KIND_CLAUSE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload select: holding register or snapshot slice, zero-extended.
    always_comb begin
        w_data = '0;
        case (r_state)
            ST_EMIT_C: w_data = WIDTH_DATA'(r_hold);
            ST_EMIT_V: w_data = WIDTH_DATA'(r_vars[r_idx]);
            ST_EMIT_L: w_data = WIDTH_DATA'(r_lvls[r_idx]);
            default:   w_data = '0;
        endcase
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rd_carray_o = r_rd;
    assign wr_valid_o  = r_valid;
    assign wr_kind_o   = r_kind;
    assign wr_idx_o    = 8'(r_idx);
    assign wr_bin_o    = r_bin;
    assign wr_data_o   = w_data;

endmodule
